uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; consumes the 16x oversample enable pulse from the baud generator and the raw serial rx pin.
- Recovers 8N1 frames (8E1 with the optional feature) by sampling each bit at its centre.
- Presents received bytes on a valid/ready output handshake to the command/control logic.
- Flags framing errors and overruns.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; must be even and >= 4; must match the baud generator setting.
- DATA_BITS, 8, data bits per frame; shifted in LSB first.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  single-cycle enable pulse at OVERSAMPLE x baud rate, from the baud generator.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- data  output  DATA_BITS  received byte; stable while valid=1.
- valid  output  1  byte available.
- ready  input  1  consumer accepts the byte when valid&&ready.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- overrun  output  1  one-cycle pulse; new byte completed while previous byte was unconsumed.

Behaviour:
- Reset and synchronisation
  - rst_n low forces, asynchronously: state IDLE, counters 0, synchroniser flops 1, data 0, valid 0, frame_err 0, overrun 0.
  - rx passes through a 2-flop synchroniser (rx_s) before any use.
- Counters
  - tick_cnt is $clog2(OVERSAMPLE) bits wide; bit_cnt is $clog2(DATA_BITS+1) bits wide.
  - Both advance only in cycles where tick=1. Non-tick cycles hold all FSM state.
- State IDLE
  - On tick with rx_s=0: go to START with tick_cnt=0.
- State START
  - On each tick, increment tick_cnt.
  - When tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1: false start; go to IDLE with no outputs.
- State DATA
  - On tick with tick_cnt==OVERSAMPLE-1: sample rx_s into shift register MSB and shift right (LSB first), tick_cnt=0, bit_cnt+1.
  - After the DATA_BITS-th sample: go to STOP (or PARITY if the feature is enabled).
- State STOP
  - On tick with tick_cnt==OVERSAMPLE-1, sample rx_s, then go to IDLE:
    - rx_s=1: byte completes.
    - rx_s=0: frame_err pulses high for the next clk cycle; byte discarded; data and valid untouched.
  - Returning to IDLE at mid-stop lets a back-to-back start edge be detected.
- Output latency
  - valid (and a new data value) asserts on the clk edge after the tick that sampled the stop bit.
- Handshake
  - valid stays high until valid&&ready, then clears on the next edge.
  - Byte completes while valid=1 and ready=0: keep the old data, discard the new byte, pulse overrun for one cycle.
  - Byte completes in the same cycle as valid&&ready: load the new byte, valid stays 1, no overrun.
- Error pulses
  - frame_err and overrun are never high for more than one cycle per event.
- Reset mid-frame
  - Partial byte is lost.
  - After release, the receiver waits in IDLE for the next falling edge; if rx is already low at release, that counts as a start edge and is validated normally.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP and output port parity_err (1-bit, one-cycle pulse).
  - At mid parity bit, compare with even parity (XOR of the data bits).
  - On mismatch: pulse parity_err, discard the byte, but still traverse STOP (frame_err is still checked).
- Undefined:
  - No PARITY state, no parity_err port; frame is 8N1.

Test Plan:
- Setup: clk 100 MHz; tick every 54 clocks (16 x 115200); bit period 864 clocks.
- 8N1 byte 0xA5, ready=1 -> valid high exactly 1 cycle, data=0xA5, frame_err=0, overrun=0.
- rx low for 4 ticks, then high -> false start; valid=0, frame_err=0; next frame 0x3C received correctly.
- Byte 0x3C with stop bit driven 0 -> frame_err pulses 1 cycle; valid stays 0; data unchanged.
- Back-to-back 0x11 then 0x22 with ready=0 -> valid held, data=0x11, overrun pulses once at second completion. Then ready=1 -> valid clears.
- rst_n pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately; subsequent 0x5A received correctly.
- With UART_RX_PARITY_EN:
  - 0x07 with parity bit 1 -> valid, data=0x07.
  - 0x07 with parity bit 0 -> parity_err pulse, valid=0.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined)
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_rx_meta;
    logic                   r_rx_s;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) begin
                            r_state    <= S_START;
                            r_tick_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tick_cnt == TC_MID) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= r_rx_s ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_tick_cnt == TC_LAST) begin
                            r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (r_tick_cnt == TC_LAST) begin
                            r_par_bad  <= (r_rx_s != ^r_shift);
                            parity_err <= (r_rx_s != ^r_shift);
                            r_tick_cnt <= '0;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        // Leave at mid-stop so a back-to-back start edge is not missed
                        if (r_tick_cnt == TC_LAST) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_IDLE;
                            if (!r_rx_s) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (!r_par_bad) begin
`else
                            end else begin
`endif
                                if (!valid || ready) begin
                                    data  <= r_shift;
                                    valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx with a frame-level outcome model
module tb_uart_rx;

    localparam int BITP  = 864;
    localparam int TICKP = 54;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model: expected accepted bytes and expected error-pulse counts
    logic [7:0] acc_q[$];
    bit         m_pending = 1'b0;
    logic [7:0] m_data    = 8'h00;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int obs_fe = 0, obs_ov = 0, obs_pe = 0;
    int n_valid_cyc = 0;
    logic prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        tick = 1'b0;
        forever begin
            for (int i = 0; i < TICKP - 1; i++) begin
                @(posedge clk);
                #2;
                tick = 1'b0;
            end
            @(posedge clk);
            #2;
            tick = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic pe_now;
`ifdef UART_RX_PARITY_EN
            pe_now = parity_err;
`else
            pe_now = 1'b0;
`endif
            if (valid) n_valid_cyc++;
            if (valid && ready) begin
                if (acc_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_accept: got data %0h, expected no byte", data);
                end else begin
                    check("accept_data", {24'h0, data}, {24'h0, acc_q.pop_front()});
                end
            end
            if (frame_err) begin
                obs_fe++;
                check("frame_err_width", {31'h0, prev_fe}, 32'h0);
            end
            if (overrun) begin
                obs_ov++;
                check("overrun_width", {31'h0, prev_ov}, 32'h0);
            end
            if (pe_now) begin
                obs_pe++;
                check("parity_err_width", {31'h0, prev_pe}, 32'h0);
            end
            prev_fe = frame_err;
            prev_ov = overrun;
            prev_pe = pe_now;
        end
    end

    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        if (!stop_ok) exp_fe++;
        if (!par_ok) exp_pe++;
        if (stop_ok && par_ok) begin
            if (m_pending) exp_ov++;
            else begin
                m_pending = 1'b1;
                m_data    = b;
            end
        end
        if (ready && m_pending) begin
            acc_q.push_back(m_data);
            m_pending = 1'b0;
        end
    endtask

    task automatic model_ready();
        ready = 1'b1;
        if (m_pending) begin
            acc_q.push_back(m_data);
            m_pending = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bit);
        bit par_ok;
        par_ok = 1'b1;
        rx = 1'b0;
        cyc(BITP);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(BITP);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        cyc(BITP);
        par_ok = (par_bit == ^b);
`endif
        model_frame(b, stop_ok, par_ok);
        rx = stop_ok;
        cyc(BITP);
        rx = 1'b1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_err_count"}, obs_fe, exp_fe);
        check({tag, "_overrun_count"}, obs_ov, exp_ov);
        check({tag, "_parity_err_count"}, obs_pe, exp_pe);
        check({tag, "_bytes_outstanding"}, acc_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        cyc(3);
        check("reset_data", {24'h0, data}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;
        cyc(BITP);

        n_valid_cyc = 0;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        cyc(20);
        check("a5_valid_cycles", n_valid_cyc, 1);
        check("a5_data", {24'h0, data}, 32'hA5);
        check("a5_valid_after", {31'h0, valid}, 32'h0);
        check_counts("a5");

        n_valid_cyc = 0;
        rx = 1'b0;
        cyc(4 * TICKP);
        rx = 1'b1;
        cyc(BITP);
        check("false_start_valid_cycles", n_valid_cyc, 0);
        check("false_start_data", {24'h0, data}, 32'hA5);
        check_counts("false_start");
        send_frame(8'h3C, 1'b1, ^8'h3C);
        cyc(20);
        check("3c_data", {24'h0, data}, 32'h3C);
        check_counts("3c");

        n_valid_cyc = 0;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        cyc(BITP);
        check("ferr_valid_cycles", n_valid_cyc, 0);
        check("ferr_data", {24'h0, data}, 32'h3C);
        check("ferr_count_literal", obs_fe, 1);
        check_counts("ferr");

        ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        cyc(20);
        check("ovr_valid_held", {31'h0, valid}, 32'h1);
        check("ovr_data", {24'h0, data}, 32'h11);
        check("ovr_count_literal", obs_ov, 1);
        model_ready();
        cyc(3);
        check("ovr_valid_cleared", {31'h0, valid}, 32'h0);
        check_counts("ovr");

        rx = 1'b0;
        cyc(BITP);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            cyc(BITP);
        end
        cyc(BITP / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
        check("midrst_overrun", {31'h0, overrun}, 32'h0);
        acc_q.delete();
        m_pending = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4 * BITP);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        cyc(20);
        check("5a_data", {24'h0, data}, 32'h5A);
        check_counts("5a");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        cyc(20);
        check("par_ok_data", {24'h0, data}, 32'h07);
        n_valid_cyc = 0;
        send_frame(8'h07, 1'b1, 1'b0);
        cyc(20);
        check("par_bad_valid_cycles", n_valid_cyc, 0);
        check("par_bad_count_literal", obs_pe, 1);
        check_counts("par");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
